// File: rtl/controller_sequencer.sv
// Multi-cycle control sequencer: captures an instruction on run and walks T0..T3,
// emitting an encoded bus-source select plus register load enables each cycle.
module controller_sequencer #(
  parameter logic [3:0] G_CODE    = 4'h8,
  parameter logic [3:0] EXT_CODE  = 4'hA,
  parameter logic [3:0] IDLE_CODE = 4'hF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [8:0] din,
  output logic [3:0] bus_sel,
  output logic       ir_in,
  output logic [7:0] r_in,
  output logic       a_in,
  output logic       g_in,
  output logic       addsub,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  step_t      step_r;
  logic [8:0] ir_r;
  logic [2:0] op_s;
  logic [2:0] rx_s;
  logic [2:0] ry_s;
  logic       is_arith_s;

  assign op_s       = ir_r[8:6];
  assign rx_s       = ir_r[5:3];
  assign ry_s       = ir_r[2:0];
  assign is_arith_s = (op_s[2:1] == 2'b01);

  // Step and instruction register; reset aborts any instruction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      step_r <= T0;
      ir_r   <= 9'd0;
    end else begin
      case (step_r)
        T0: begin
          if (run) begin
            ir_r   <= din;
            step_r <= T1;
          end else begin
            step_r <= T0;
          end
        end
        T1:      step_r <= is_arith_s ? T2 : T0;
        T2:      step_r <= T3;
        T3:      step_r <= T0;
        default: step_r <= T0;
      endcase
    end
  end

  // Control decode from step and IR; run only matters while waiting in T0.
  always_comb begin
    bus_sel = IDLE_CODE;
    ir_in   = 1'b0;
    r_in    = 8'h00;
    a_in    = 1'b0;
    g_in    = 1'b0;
    addsub  = 1'b0;
    done    = 1'b0;
    busy    = (step_r != T0);
    case (step_r)
      T0: begin
        ir_in = run;
      end
      T1: begin
        case (op_s)
          3'b000: begin
            bus_sel = {1'b0, ry_s};
            r_in    = 8'h01 << rx_s;
            done    = 1'b1;
          end
          3'b001: begin
            bus_sel = EXT_CODE;
            r_in    = 8'h01 << rx_s;
            done    = 1'b1;
          end
          3'b010, 3'b011: begin
            bus_sel = {1'b0, rx_s};
            a_in    = 1'b1;
          end
          default: begin
            // Reserved opcodes finish immediately as a nop.
            done = 1'b1;
          end
        endcase
      end
      T2: begin
        bus_sel = {1'b0, ry_s};
        g_in    = 1'b1;
        addsub  = op_s[0];
      end
      T3: begin
        bus_sel = G_CODE;
        r_in    = 8'h01 << rx_s;
        done    = 1'b1;
      end
      default: begin
        bus_sel = IDLE_CODE;
      end
    endcase
  end

endmodule

// File: tb/tb_controller_sequencer.sv
// Table-driven bench for controller_sequencer: one vector per clock cycle, with
// expected outputs queued on drive and popped when the cycle's outputs are sampled.
module tb_controller_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [8:0] din;
  logic [3:0] bus_sel;
  logic       ir_in;
  logic [7:0] r_in;
  logic       a_in;
  logic       g_in;
  logic       addsub;
  logic       done;
  logic       busy;

  controller_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .bus_sel (bus_sel),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .addsub  (addsub),
    .done    (done),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] bus;
    logic       ir;
    logic [7:0] r;
    logic       a;
    logic       g;
    logic       as;
    logic       dn;
    logic       by;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic [8:0] din;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add_vec(input logic rst, input logic rn, input logic [8:0] d,
                         input logic [3:0] bus, input logic ir, input logic [7:0] r,
                         input logic a, input logic g, input logic as,
                         input logic dn, input logic by);
    vec_t v;
    v.rst = rst;
    v.run = rn;
    v.din = d;
    v.exp = '{bus: bus, ir: ir, r: r, a: a, g: g, as: as, dn: dn, by: by};
    vecs.push_back(v);
  endtask

  task automatic check(input int idx, input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL vec%0d %s: got %h, expected %h", idx, name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    run   = 1'b1;
    din   = 9'h1FF;

    //        rst   run   din            bus   ir    r      a     g     as    dn    by
    // still in reset with run high: T0, ir_in follows run
    add_vec(1'b1, 1'b1, 9'h1FF,       4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 9'h000,       4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // mv r5,r2
    add_vec(1'b0, 1'b1, 9'b000101010, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 9'h000,       4'h2, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 1'b0, 9'h000,       4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // mvi r0,#7B
    add_vec(1'b0, 1'b1, 9'b001000000, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 9'h07B,       4'hA, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    // sub r1,r6
    add_vec(1'b0, 1'b1, 9'b011001110, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 9'h000,       4'h1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 9'h000,       4'h6, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 9'h000,       4'h8, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 1'b0, 9'h000,       4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // add r2,r3 aborted by reset during T2
    add_vec(1'b0, 1'b1, 9'b010010011, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 9'h000,       4'h2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b1, 1'b0, 9'h000,       4'h3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 9'h000,       4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // add r4,r5 with a stray run pulse in T2
    add_vec(1'b0, 1'b1, 9'b010100101, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 9'h000,       4'h4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 9'b000111111, 4'h5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 9'h000,       4'h8, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 1'b0, 9'h000,       4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // reserved op with run held, then mv r1,r2 captured right after done
    add_vec(1'b0, 1'b1, 9'b110011011, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 9'b000001010, 4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 1'b1, 9'b000001010, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 9'h000,       4'h2, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    // sub r3,r3: rx == ry
    add_vec(1'b0, 1'b1, 9'b011011011, 4'hF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 9'h000,       4'h3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 9'h000,       4'h3, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 9'h000,       4'h8, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_vec(1'b0, 1'b0, 9'h000,       4'hF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clock);

    for (int i = 0; i < vecs.size(); i++) begin
      #1;
      reset = vecs[i].rst;
      run   = vecs[i].run;
      din   = vecs[i].din;
      exp_q.push_back(vecs[i].exp);
      #2;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL vec%0d scoreboard: got empty queue, expected an entry", i);
      end else begin
        e = exp_q.pop_front();
        check(i, "bus_sel", {4'h0, bus_sel}, {4'h0, e.bus});
        check(i, "ir_in",   {7'h00, ir_in},  {7'h00, e.ir});
        check(i, "r_in",    r_in,            e.r);
        check(i, "a_in",    {7'h00, a_in},   {7'h00, e.a});
        check(i, "g_in",    {7'h00, g_in},   {7'h00, e.g});
        check(i, "addsub",  {7'h00, addsub}, {7'h00, e.as});
        check(i, "done",    {7'h00, done},   {7'h00, e.dn});
        check(i, "busy",    {7'h00, busy},   {7'h00, e.by});
      end
      @(posedge clock);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
